// File: rtl/otter_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : otter_fetch_queue
// Purpose  : Instruction-fetch front end for the pipelined OTTER core. Holds
//            the fetch PC, issues word reads to a 1-cycle synchronous
//            instruction memory and buffers {PC, instruction} pairs in a
//            DEPTH-entry FIFO that decode drains with a valid/ready handshake.
//            A redirect from execute flushes queued and in-flight wrong-path
//            fetches and restarts fetch at the target.
// Ports    : clk         - clock, rising edge
//            RST         - synchronous active-low reset
//            redirect    - execute requests a PC change this cycle
//            redirect_pc - redirect target (bits [1:0] ignored)
//            mem_rden    - instruction read enable
//            mem_addr    - word address of the read
//            mem_rdata   - instruction word, valid the cycle after mem_rden
//            deq_valid   - head entry available to decode
//            deq_ready   - decode accepts the head entry
//            deq_ir      - head instruction (0 when empty)
//            deq_pc      - head PC (0 when empty)
//            count       - number of occupied FIFO entries
// Revision : 1.0 - initial release
// ============================================================================
module otter_fetch_queue #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter int              MEM_AW    = 14,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     mem_rden,
  output logic [MEM_AW-1:0]        mem_addr,
  input  logic [XLEN-1:0]          mem_rdata,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [XLEN-1:0]          deq_ir,
  output logic [XLEN-1:0]          deq_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("otter_fetch_queue: DEPTH must be a power of two and at least 2");
    end
    if (XLEN < MEM_AW + 2) begin : g_width_check
      $error("otter_fetch_queue: XLEN must be at least MEM_AW+2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]  fetch_pc_q,    fetch_pc_d;
  logic             inflight_q,    inflight_d;
  logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0] head_q,        head_d;
  logic [PTR_W-1:0] tail_q,        tail_d;
  logic [CNT_W-1:0] count_q,       count_d;

  // Entry storage carries no reset: an entry is only observable once count
  // says it is occupied, and the read port is forced to 0 otherwise.
  logic [XLEN-1:0]  ir_mem_q [DEPTH];
  logic [XLEN-1:0]  pc_mem_q [DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic             not_empty;
  logic [CNT_W:0]   committed;

  // --------------------------------------------------------------------------
  // Handshake and issue decisions
  // --------------------------------------------------------------------------
  always_comb begin
    not_empty = (count_q != '0);
    deq_valid = RST & not_empty & ~redirect;
    pop       = deq_valid & deq_ready;

    // A response is only accepted on a non-redirect cycle; a redirect in the
    // same cycle means the returning word belongs to the wrong path.
    push      = RST & ~redirect & inflight_q;

    // Slots already promised: occupied entries plus the outstanding read,
    // minus the slot freed by a pop this cycle. Issuing only while this is
    // below DEPTH is what guarantees a returning word always finds space.
    committed = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}
              - {{CNT_W{1'b0}}, pop};
    issue     = RST & ~redirect & (committed < (CNT_W+1)'(DEPTH));

    mem_rden  = issue;
    mem_addr  = fetch_pc_q[MEM_AW+1:2];

    count     = RST ? count_q : '0;
    if (RST && not_empty) begin
      deq_ir = ir_mem_q[head_q];
      deq_pc = pc_mem_q[head_q];
    end else begin
      deq_ir = '0;
      deq_pc = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (redirect) begin
      // Flush everything; the target is fetched starting next cycle.
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + XLEN'(4);
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!RST) begin
      fetch_pc_q    <= RESET_VEC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Entry storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      ir_mem_q[tail_q] <= mem_rdata;
      pc_mem_q[tail_q] <= inflight_pc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_otter_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_otter_fetch_queue
// Purpose  : Self-checking bench for otter_fetch_queue (DEPTH=4, RESET_VEC=0).
//            A queue-based behavioural model is compared against the DUT on
//            every cycle, alongside hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_otter_fetch_queue;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 4;
  localparam int MEM_AW = 14;

  logic              clk = 1'b0;
  logic              RST;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic              mem_rden;
  logic [MEM_AW-1:0] mem_addr;
  logic [XLEN-1:0]   mem_rdata = '0;
  logic              deq_valid;
  logic              deq_ready;
  logic [XLEN-1:0]   deq_ir;
  logic [XLEN-1:0]   deq_pc;
  logic [2:0]        count;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;
  bit seen_200 = 1'b0;

  otter_fetch_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MEM_AW(MEM_AW), .RESET_VEC(32'h0)
  ) dut (
    .clk(clk), .RST(RST), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_ir(deq_ir),
    .deq_pc(deq_pc), .count(count)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word at byte address A is A + 0x1000.
  always @(posedge clk) begin
    if (mem_rden) mem_rdata <= 32'({mem_addr, 2'b00}) + 32'h1000;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: an ordered list of fetched {pc, ir}, the fetch PC and
  // at most one outstanding read.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_fpc  = 32'h0;
  logic [31:0] m_ipc  = 32'h0;
  bit          m_infl = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      int   sz;
      bit   e_valid, e_pop, e_issue;
      ent_t e_head;
      sz      = m_q.size();
      e_valid = RST && (sz != 0) && !redirect;
      e_pop   = e_valid && deq_ready;
      e_issue = RST && !redirect && ((sz + int'(m_infl) - int'(e_pop)) < DEPTH);
      e_head  = (RST && sz != 0) ? m_q[0] : '0;

      chk("count",     32'(count),     RST ? 32'(sz) : 32'h0);
      chk("deq_valid", 32'(deq_valid), 32'(e_valid));
      chk("deq_pc",    deq_pc,         e_head.pc);
      chk("deq_ir",    deq_ir,         e_head.ir);
      chk("mem_rden",  32'(mem_rden),  32'(e_issue));
      chk("mem_addr",  32'(mem_addr),  32'(m_fpc[15:2]));
      chk("invariant", 32'((int'(count) + int'(m_infl)) <= DEPTH), 32'h1);

      if (deq_valid && deq_pc == 32'h200) seen_200 = 1'b1;

      // Advance the model to the state after the coming rising edge.
      if (!RST) begin
        m_q.delete();
        m_fpc  = 32'h0;
        m_infl = 1'b0;
      end else if (redirect) begin
        m_q.delete();
        m_infl = 1'b0;
        m_fpc  = redirect_pc & ~32'h3;
      end else begin
        if (e_pop) void'(m_q.pop_front());
        if (m_infl) m_q.push_back('{pc: m_ipc, ir: m_ipc + 32'h1000});
        if (e_issue) begin
          m_ipc  = m_fpc;
          m_fpc  = m_fpc + 32'h4;
          m_infl = 1'b1;
        end else begin
          m_infl = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // --------------------------------------------------------------------------
  initial begin
    RST         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    deq_ready   = 1'b1;

    step();
    cmp_en = 1'b1;
    step();
    @(negedge clk);
    chk("rst_count", 32'(count),     32'h0);
    chk("rst_valid", 32'(deq_valid), 32'h0);
    chk("rst_rden",  32'(mem_rden),  32'h0);
    chk("rst_ir",    deq_ir,         32'h0);

    // Reset release: addresses 0,1,2 and first instruction two cycles later.
    step(); RST = 1'b1;
    @(negedge clk);
    chk("rel_rden0", 32'(mem_rden), 32'h1);
    chk("rel_addr0", 32'(mem_addr), 32'h0);
    step();
    @(negedge clk);
    chk("rel_addr1",  32'(mem_addr),  32'h1);
    chk("rel_valid1", 32'(deq_valid), 32'h0);
    step();
    @(negedge clk);
    chk("rel_valid2", 32'(deq_valid), 32'h1);
    chk("rel_pc2",    deq_pc,         32'h0);
    chk("rel_ir2",    deq_ir,         32'h1000);
    step();
    @(negedge clk);
    chk("rel_pc3", deq_pc, 32'h4);
    chk("rel_ir3", deq_ir, 32'h1004);
    repeat (3) step();

    // Decode stall for 10 cycles: queue fills to DEPTH and fetch stops.
    deq_ready = 1'b0;
    repeat (9) step();
    @(negedge clk);
    chk("stall_count", 32'(count),    32'h4);
    chk("stall_rden",  32'(mem_rden), 32'h0);

    // Release from full: fetch issues every cycle while draining.
    step(); deq_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_rden",  32'(mem_rden),  32'h1);
      chk("full_valid", 32'(deq_valid), 32'h1);
      step();
    end

    // Redirect to 0x103 with three entries queued and a fetch in flight.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    chk("redir_count_pre", 32'(count),     32'h3);
    chk("redir_valid",     32'(deq_valid), 32'h0);
    chk("redir_rden",      32'(mem_rden),  32'h0);
    step(); redirect = 1'b0;
    @(negedge clk);
    chk("redir_count", 32'(count),     32'h0);
    chk("redir_valid1", 32'(deq_valid), 32'h0);
    chk("redir_addr",  32'(mem_addr),  32'h40);
    chk("redir_rden1", 32'(mem_rden),  32'h1);
    step(); step();
    @(negedge clk);
    chk("redir_tgt_valid", 32'(deq_valid), 32'h1);
    chk("redir_tgt_pc",    deq_pc,         32'h100);
    chk("redir_tgt_ir",    deq_ir,         32'h1100);

    // Back-to-back redirects: 0x200 then 0x300; only 0x300 is fetched.
    step(); redirect = 1'b1; redirect_pc = 32'h200;
    step(); redirect_pc = 32'h300;
    step(); redirect = 1'b0;
    @(negedge clk);
    chk("b2b_addr", 32'(mem_addr), 32'hC0);
    step(); step();
    @(negedge clk);
    chk("b2b_pc", deq_pc, 32'h300);
    repeat (3) step();
    chk("b2b_no_200", 32'(seen_200), 32'h0);

    // Reset mid-stream together with a redirect while two entries are queued.
    deq_ready = 1'b0;
    for (int i = 0; i < 8 && m_q.size() != 2; i++) step();
    chk("mid_reach2", 32'(m_q.size()), 32'h2);
    RST         = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h500;
    @(negedge clk);
    chk("mid_count", 32'(count),     32'h0);
    chk("mid_valid", 32'(deq_valid), 32'h0);
    chk("mid_rden",  32'(mem_rden),  32'h0);
    step(); RST = 1'b1; redirect = 1'b0; deq_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_rden", 32'(mem_rden), 32'h1);
    chk("mid_rst_addr", 32'(mem_addr), 32'h0);
    step(); step();
    @(negedge clk);
    chk("mid_rst_pc", deq_pc, 32'h0);
    chk("mid_rst_ir", deq_ir, 32'h1000);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
